// File: rtl/pcm_pkg.sv
// Shared widths and state encoding for the PCM single-entry memory register.
package pcm_pkg;

  localparam int unsigned PcmAddrW = 20;
  localparam int unsigned PcmDataW = 16;

  // StMiss is a valid entry whose address no longer matches the request.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StValid = 2'd1,
    StMiss  = 2'd2
  } pcm_state_e;

endpackage

// File: rtl/pcm_addr_cmp.sv
// Full-width address comparator producing the hit flag for the held entry.
module pcm_addr_cmp #(
  parameter int unsigned ADDR_W = 20
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] addr_reg,
  input  logic              valid,
  output logic              hit
);

  assign hit = valid && (addr == addr_reg);

endmodule

// File: rtl/pcm_mm_reg.sv
// Single-entry PCM memory register: serves hits combinationally, schedules misses to memory.
module pcm_mm_reg
  import pcm_pkg::*;
#(
  parameter int unsigned ADDR_W = PcmAddrW,
  parameter int unsigned DATA_W = PcmDataW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic [ADDR_W-1:0] addr,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              resolved,
  output logic              schedule,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_out,
  output logic [ADDR_W-1:0] addr_reg
);

  pcm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              valid;
  logic              hit;
  logic              fill;

  assign valid = (state_q != StEmpty);

  pcm_addr_cmp #(
    .ADDR_W(ADDR_W)
  ) u_addr_cmp (
    .addr    (addr),
    .addr_reg(addr_q),
    .valid   (valid),
    .hit     (hit)
  );

  // Resolved only counts while a miss is outstanding; init takes precedence.
  assign fill = !init && !hit && resolved;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: begin
        if (init || fill) state_d = StValid;
      end
      StValid: begin
        if (!init && !hit && !resolved) state_d = StMiss;
      end
      StMiss: begin
        if (init || fill || hit) state_d = StValid;
      end
      default: state_d = StEmpty;
    endcase
  end

  always_comb begin
    schedule  = !init && !hit;
    cpu_ready = hit && !init;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q <= '0;
      data_q <= '0;
    end else if (init) begin
      addr_q <= addr;
      data_q <= data_in;
    end else if (fill) begin
      addr_q <= addr;
      data_q <= cpu_write ? cpu_in : data_in;
    end else if (hit && cpu_write) begin
      data_q <= cpu_in;
    end
  end

  assign cpu_out  = data_q;
  assign addr_reg = addr_q;

endmodule

// File: tb/tb_pcm_mm_reg.sv
// Self-checking bench for pcm_mm_reg: directed scenarios plus randomized traffic vs a reference model.
module tb_pcm_mm_reg;

  localparam int unsigned AW = 20;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          init;
  logic [AW-1:0] addr;
  logic          cpu_write;
  logic [DW-1:0] cpu_in;
  logic [DW-1:0] data_in;
  logic          resolved;
  logic          schedule;
  logic          cpu_ready;
  logic [DW-1:0] cpu_out;
  logic [AW-1:0] addr_reg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model of the single held entry.
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [DW-1:0] m_data  = '0;

  always #5 clk = ~clk;

  pcm_mm_reg #(
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .init     (init),
    .addr     (addr),
    .cpu_write(cpu_write),
    .cpu_in   (cpu_in),
    .data_in  (data_in),
    .resolved (resolved),
    .schedule (schedule),
    .cpu_ready(cpu_ready),
    .cpu_out  (cpu_out),
    .addr_reg (addr_reg)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic exp_hit;
    exp_hit = m_valid && (addr == m_addr);
    check_eq({tag, ".schedule"}, 32'(schedule), 32'(!init && !exp_hit));
    check_eq({tag, ".cpu_ready"}, 32'(cpu_ready), 32'(exp_hit && !init));
    check_eq({tag, ".cpu_out"}, 32'(cpu_out), 32'(m_data));
    check_eq({tag, ".addr_reg"}, 32'(addr_reg), 32'(m_addr));
  endtask

  task automatic expect_outs(input string tag, input logic sch, input logic rdy,
                             input logic [DW-1:0] out, input logic [AW-1:0] areg);
    check_eq({tag, ".schedule"}, 32'(schedule), 32'(sch));
    check_eq({tag, ".cpu_ready"}, 32'(cpu_ready), 32'(rdy));
    check_eq({tag, ".cpu_out"}, 32'(cpu_out), 32'(out));
    check_eq({tag, ".addr_reg"}, 32'(addr_reg), 32'(areg));
  endtask

  // Drive a full input vector away from the active edge, then compare against the model.
  task automatic apply(input string tag, input logic r, input logic i, input logic [AW-1:0] a,
                       input logic w, input logic [DW-1:0] ci, input logic [DW-1:0] di,
                       input logic res);
    @(negedge clk);
    reset = r; init = i; addr = a; cpu_write = w; cpu_in = ci; data_in = di; resolved = res;
    #1;
    if (reset) check_model(tag);
  endtask

  // Advance one rising edge and apply the behavioural update rules with their priority.
  task automatic tick();
    logic hit;
    @(posedge clk);
    hit = m_valid && (addr == m_addr);
    if (!reset) begin
      m_valid = 1'b0; m_addr = '0; m_data = '0;
    end else if (init) begin
      m_valid = 1'b1; m_addr = addr; m_data = data_in;
    end else if (!hit && resolved) begin
      m_valid = 1'b1; m_addr = addr; m_data = cpu_write ? cpu_in : data_in;
    end else if (hit && cpu_write) begin
      m_data = cpu_in;
    end
    #1;
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; addr = '0; cpu_write = 1'b0;
    cpu_in = '0; data_in = '0; resolved = 1'b0;

    // Reset and post-reset values.
    apply("rst", 1'b0, 1'b0, 20'h00000, 1'b0, 16'h0, 16'h0, 1'b0);
    tick();
    apply("post_rst", 1'b1, 1'b0, 20'h00000, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("post_rst_k", 1'b1, 1'b0, 16'h0000, 20'h00000);
    tick();

    // Init load.
    apply("init", 1'b1, 1'b1, 20'h00000, 1'b0, 16'h0, 16'h0101, 1'b0);
    expect_outs("init_k", 1'b0, 1'b0, 16'h0000, 20'h00000);
    tick();
    apply("after_init", 1'b1, 1'b0, 20'h00000, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("after_init_k", 1'b0, 1'b1, 16'h0101, 20'h00000);
    tick();

    // Miss at the top address, combinational schedule, then fill.
    apply("miss_top", 1'b1, 1'b0, 20'hFFFFF, 1'b0, 16'h0, 16'h0FF0, 1'b1);
    expect_outs("miss_top_k", 1'b1, 1'b0, 16'h0101, 20'h00000);
    tick();
    apply("fill_top", 1'b1, 1'b0, 20'hFFFFF, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("fill_top_k", 1'b0, 1'b1, 16'h0FF0, 20'hFFFFF);
    tick();

    // Write hit.
    apply("wr_hit", 1'b1, 1'b0, 20'hFFFFF, 1'b1, 16'hBEEF, 16'h0, 1'b0);
    tick();
    apply("after_wr_hit", 1'b1, 1'b0, 20'hFFFFF, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("after_wr_hit_k", 1'b0, 1'b1, 16'hBEEF, 20'hFFFFF);
    tick();

    // Write miss resolves with CPU data, not memory data.
    apply("wr_miss", 1'b1, 1'b0, 20'h12345, 1'b1, 16'h1234, 16'h5555, 1'b1);
    tick();
    apply("after_wr_miss", 1'b1, 1'b0, 20'h12345, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("after_wr_miss_k", 1'b0, 1'b1, 16'h1234, 20'h12345);
    tick();

    // Init beats resolved and cpu_write.
    apply("init_res", 1'b1, 1'b1, 20'h00ABC, 1'b1, 16'h4444, 16'h7777, 1'b1);
    tick();
    apply("after_init_res", 1'b1, 1'b0, 20'h00ABC, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("after_init_res_k", 1'b0, 1'b1, 16'h7777, 20'h00ABC);
    tick();

    // Resolved during a hit is ignored.
    apply("res_hit", 1'b1, 1'b0, 20'h00ABC, 1'b0, 16'h0, 16'h1111, 1'b1);
    tick();
    apply("after_res_hit", 1'b1, 1'b0, 20'h00ABC, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("after_res_hit_k", 1'b0, 1'b1, 16'h7777, 20'h00ABC);
    tick();

    // Reset in the middle of a miss discards it despite init/resolved.
    apply("pre_rst_miss", 1'b1, 1'b0, 20'h00001, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("pre_rst_miss_k", 1'b1, 1'b0, 16'h7777, 20'h00ABC);
    tick();
    apply("rst_miss", 1'b0, 1'b1, 20'h00001, 1'b1, 16'h2222, 16'h3333, 1'b1);
    tick();
    apply("after_rst_miss", 1'b1, 1'b0, 20'h00001, 1'b0, 16'h0, 16'h0, 1'b0);
    expect_outs("after_rst_miss_k", 1'b1, 1'b0, 16'h0000, 20'h00000);
    tick();

    // Randomized traffic biased towards the held address so hits and misses both occur.
    for (int k = 0; k < 400; k++) begin
      logic [AW-1:0] a;
      case ($urandom_range(3))
        0: a = m_addr;
        1: a = 20'hFFFFF;
        2: a = AW'($urandom_range(7));
        default: a = AW'($urandom);
      endcase
      apply("rand", ($urandom_range(39) != 0), ($urandom_range(9) == 0), a,
            1'($urandom), DW'($urandom), DW'($urandom), ($urandom_range(2) == 0));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
